// File: rtl/ps2_key_source_if.sv
// Key handshake between the PS/2 key source (master) and the tone synthesizer (slave).
interface ps2_key_source_if;
    logic [3:0] keycode;
    logic       data_ready;
    logic       data_request;

    modport master (output keycode, output data_ready, input data_request);
    modport slave  (input keycode, input data_ready, output data_request);
endinterface

// File: rtl/ps2_key_source.sv
// PS/2 receiver + scan decoder presenting number-row keys 1..7 to the synthesizer; optional PS2_ERR_CNT_EN adds err_count.
// Latency: data_ready changes 4 CLOCK_50 cycles after the 11th PS2_CLK falling edge at the pin.
// Backpressure: makes arriving while data_request=0 are dropped; PS/2 line is never driven.
module ps2_key_source #(
    parameter int TIMEOUT_CLKS = 50000,
    parameter int CNT_W        = 16
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               PS2_CLK,
    input  logic               PS2_DAT,
    ps2_key_source_if.master   key
`ifdef PS2_ERR_CNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_WAIT} state_t;

    logic             clk_s1, clk_s2, clk_prev;
    logic             dat_s1, dat_s2;
    logic             fall;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout;
    logic             frame_ok;
    logic             frame_bad;
    logic             byte_valid;
    logic [7:0]       byte_dat;
    logic             brk, ext;
    logic             is_f0, is_e0;
    logic [3:0]       code;
    logic             key_evt, key_make, key_break;
    state_t           state, state_nxt;
    logic             load_key;
    logic [3:0]       keycode_q;

    // Sync registers reset high so reset never fakes a falling edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    assign fall      = clk_prev & ~clk_s2;
    // shreg holds bits 0..9 (start at [0], parity at [9]); the stop bit is the live sample.
    assign frame_ok  = ~shreg[0] & dat_s2 & (^shreg[9:1]);
    assign frame_bad = fall && (bit_cnt == 4'd10) && !frame_ok;
    assign timeout   = !fall && (bit_cnt != 4'd0) && (wd_cnt == CNT_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= 10'd0;
            wd_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_dat   <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            if (fall) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt    <= 4'd0;
                    byte_valid <= frame_ok;
                    byte_dat   <= shreg[8:1];
                end else begin
                    shreg   <= {dat_s2, shreg[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (timeout) begin
                    bit_cnt <= 4'd0;
                    wd_cnt  <= '0;
                end else begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign is_f0 = (byte_dat == 8'hF0);
    assign is_e0 = (byte_dat == 8'hE0);

    always_comb begin
        code = 4'd0;
        case (byte_dat)
            8'h16:   code = 4'd1;
            8'h1E:   code = 4'd2;
            8'h26:   code = 4'd3;
            8'h25:   code = 4'd4;
            8'h2E:   code = 4'd5;
            8'h36:   code = 4'd6;
            8'h3D:   code = 4'd7;
            default: code = 4'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            brk <= 1'b0;
            ext <= 1'b0;
        end else if (byte_valid) begin
            if (is_f0) begin
                brk <= 1'b1;
            end else if (is_e0) begin
                ext <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    assign key_evt   = byte_valid && !is_f0 && !is_e0 && !ext && (code != 4'd0);
    assign key_make  = key_evt && !brk;
    assign key_break = key_evt && brk;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            keycode_q <= 4'd0;
        end else begin
            state <= state_nxt;
            if (load_key) begin
                keycode_q <= code;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (key_make && key.data_request) begin
                    state_nxt = ST_HELD;
                    load_key  = 1'b1;
                end
            end
            ST_HELD: begin
                if (key_break && (code == keycode_q)) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!key.data_request) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign key.keycode    = keycode_q;
    assign key.data_ready = (state == ST_HELD);

`ifdef PS2_ERR_CNT_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if ((frame_bad || timeout) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule
